tach_rpm_estimator: RTL and testbench



---
 rtl/tach_rpm_estimator.sv | 138 +++++++++++++
 tb/tb_tach_rpm_estimator.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/tach_rpm_estimator.sv
// Tachometer pulse train to saturated RPM: edge period in clk_en ticks, then K/period by restoring division.
// Latency: rpm_valid pulses DIV_W+2 clk after the clk_en cycle that accepted the measuring edge.
// Backpressure: none; free-running input, single-cycle rpm_valid strobe with rpm_out held between updates.
`timescale 1ns/1ps
module tach_rpm_estimator #(
    parameter int TICK_HZ          = 10000,
    parameter int PPR              = 12,
    parameter int RPM_W            = 10,
    parameter int CNT_W            = 13,
    parameter int TIMEOUT_TICKS    = 5000,
    parameter int MIN_PERIOD_TICKS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             tach_in,
    output logic [RPM_W-1:0] rpm_out,
    output logic             rpm_valid,
    output logic             stalled
);

    localparam int K     = 60 * TICK_HZ / PPR;
    localparam int DIV_W = $clog2(K + 1);
    localparam int IT_W  = $clog2(DIV_W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [DIV_W-1:0] RPM_MAX = DIV_W'((1 << RPM_W) - 1);

    logic             sync1, sync2, s_prev;
    logic [CNT_W-1:0] cnt;
    logic             armed;
    logic [1:0]       state;
    logic [IT_W-1:0]  it_cnt;
    logic [DIV_W:0]   rem;
    logic [DIV_W-1:0] quo;
    logic [DIV_W:0]   dvs;

    logic [CNT_W-1:0] p_val;
    logic             rise, accept, stall_hit, start;
    logic [DIV_W+1:0] shifted, diff;

    // Edge qualification, period value and divider trial subtraction.
    always_comb begin
        p_val     = cnt + CNT_W'(1);
        rise      = clk_en & sync2 & ~s_prev;
        accept    = rise & (~armed | (p_val >= CNT_W'(MIN_PERIOD_TICKS)));
        stall_hit = clk_en & ~accept & (p_val == CNT_W'(TIMEOUT_TICKS));
        start     = accept & armed & (state == S_IDLE);
        shifted   = {rem, quo[DIV_W-1]};
        diff      = shifted - {1'b0, dvs};
    end

    // Two-flop synchronizer, tick-rate sampling and period counter with arming.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            s_prev <= 1'b0;
            cnt    <= '0;
            armed  <= 1'b0;
        end else begin
            sync1 <= tach_in;
            sync2 <= sync1;
            if (clk_en) begin
                s_prev <= sync2;
                if (accept) begin
                    cnt   <= '0;
                    armed <= 1'b1;
                end else if (stall_hit) begin
                    cnt   <= '0;
                    armed <= 1'b0;
                end else begin
                    cnt <= p_val;
                end
            end
        end
    end

    // Divider FSM and output registers; a stall aborts any division in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            it_cnt    <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            rpm_out   <= '0;
            rpm_valid <= 1'b0;
            stalled   <= 1'b1;
        end else begin
            rpm_valid <= 1'b0;
            if (stall_hit) begin
                state     <= S_IDLE;
                rpm_out   <= '0;
                stalled   <= 1'b1;
                rpm_valid <= ~stalled;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            rem    <= '0;
                            quo    <= DIV_W'(K);
                            dvs    <= (DIV_W+1)'(p_val);
                            it_cnt <= '0;
                            state  <= S_DIV;
                        end
                    end
                    S_DIV: begin
                        if (!diff[DIV_W+1]) begin
                            rem <= diff[DIV_W:0];
                            quo <= {quo[DIV_W-2:0], 1'b1};
                        end else begin
                            rem <= shifted[DIV_W:0];
                            quo <= {quo[DIV_W-2:0], 1'b0};
                        end
                        it_cnt <= it_cnt + IT_W'(1);
                        if (it_cnt == IT_W'(DIV_W - 1)) begin
                            state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        rpm_out   <= (quo > RPM_MAX) ? {RPM_W{1'b1}} : quo[RPM_W-1:0];
                        rpm_valid <= 1'b1;
                        stalled   <= 1'b0;
                        state     <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tach_rpm_estimator.sv
// Directed bench for tach_rpm_estimator with hand-computed RPM values (K = 50000).
// clk_en ticks are spaced 2 clk while idle and ~28 clk around edges so divisions complete.
// Outputs are sampled 1 ns after the active edge or on the falling edge.
`timescale 1ns/1ps
module tb_tach_rpm_estimator;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       clk_en  = 1'b0;
    logic       tach_in = 1'b0;
    logic [9:0] rpm_out;
    logic       rpm_valid;
    logic       stalled;

    int n_cmp   = 0;
    int n_bad   = 0;
    int vld_cnt = 0;
    int run_cnt = 0;

    tach_rpm_estimator dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .tach_in   (tach_in),
        .rpm_out   (rpm_out),
        .rpm_valid (rpm_valid),
        .stalled   (stalled)
    );

    always #4 clk = ~clk;

    // Count rpm_valid pulses and cycles with stalled low.
    always @(negedge clk) begin
        if (rpm_valid) vld_cnt++;
        if (!stalled)  run_cnt++;
    end

    task automatic check_val(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) clk_en = 1'b1;
            @(negedge clk) clk_en = 1'b0;
        end
    endtask

    // One tick carrying a rising tach edge; reports latency (cycle index of rpm_valid
    // counting the clk_en cycle as 0, -1 if none) and rpm_out at that pulse.
    // rst_at > 0 pulses reset from that many clk after the tick for 2 clk.
    task automatic edge_tick(input int rst_at, output int lat, output int val);
        lat = -1;
        val = -1;
        @(negedge clk) tach_in = 1'b1;
        repeat (3) @(negedge clk);
        clk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clk_en  = 1'b0;
        tach_in = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            if (k == rst_at) reset = 1'b1;
            if (rst_at > 0 && k == rst_at + 2) reset = 1'b0;
            if (rpm_valid && lat < 0) begin
                lat = k + 1;
                val = int'(rpm_out);
            end
        end
        @(negedge clk);
    endtask

    int lat, val, v0, r0;

    initial begin
        repeat (3) @(negedge clk);
        check_val("reset_rpm_out", int'(rpm_out), 0);
        check_val("reset_rpm_valid", int'(rpm_valid), 0);
        check_val("reset_stalled", int'(stalled), 1);
        reset = 1'b0;

        // No pulses for 5000 ticks: stays stalled, no update.
        v0 = vld_cnt; r0 = run_cnt;
        idle_ticks(5000);
        repeat (2) @(negedge clk);
        check_val("idle_vld_pulses", vld_cnt - v0, 0);
        check_val("idle_stalled_low_cycles", run_cnt - r0, 0);
        check_val("idle_rpm_out", int'(rpm_out), 0);
        check_val("idle_stalled", int'(stalled), 1);

        // 500-tick train: first edge arms, then 100 RPM with 18-cycle latency.
        edge_tick(0, lat, val);
        check_val("arm_edge_no_update", lat, -1);
        idle_ticks(499);
        edge_tick(0, lat, val);
        check_val("p500_latency", lat, 18);
        check_val("p500_rpm", val, 100);
        check_val("p500_stalled", int'(stalled), 0);
        idle_ticks(499);
        edge_tick(0, lat, val);
        check_val("p500_repeat_rpm", val, 100);

        // Glitch 3 ticks after an accepted edge is ignored.
        idle_ticks(2);
        edge_tick(0, lat, val);
        check_val("glitch_no_update", lat, -1);
        idle_ticks(496);
        edge_tick(0, lat, val);
        check_val("after_glitch_rpm", val, 100);
        check_val("after_glitch_latency", lat, 18);

        // Saturation at 40 ticks (1250 -> 1023), 49 ticks -> 1020.
        idle_ticks(39);
        edge_tick(0, lat, val);
        check_val("p40_saturated", val, 1023);
        idle_ticks(48);
        edge_tick(0, lat, val);
        check_val("p49_rpm", val, 1020);
        idle_ticks(499);
        edge_tick(0, lat, val);
        check_val("back_to_100", val, 100);

        // Pulses stop: stall exactly 5000 ticks after the last accepted edge.
        v0 = vld_cnt;
        idle_ticks(4999);
        repeat (2) @(negedge clk);
        check_val("pre_stall_rpm", int'(rpm_out), 100);
        check_val("pre_stall_stalled", int'(stalled), 0);
        check_val("pre_stall_vld", vld_cnt - v0, 0);
        idle_ticks(1);
        repeat (2) @(negedge clk);
        check_val("stall_rpm", int'(rpm_out), 0);
        check_val("stall_stalled", int'(stalled), 1);
        check_val("stall_vld_once", vld_cnt - v0, 1);

        // Restart at 250 ticks: first edge arms, second gives 200.
        edge_tick(0, lat, val);
        check_val("restart_arm_no_update", lat, -1);
        idle_ticks(249);
        edge_tick(0, lat, val);
        check_val("p250_rpm", val, 200);

        // Reset 5 clk into a division: no pulse, reset values.
        idle_ticks(249);
        v0 = vld_cnt;
        edge_tick(5, lat, val);
        repeat (2) @(negedge clk);
        check_val("rst_div_no_pulse", lat, -1);
        check_val("rst_div_vld_count", vld_cnt - v0, 0);
        check_val("rst_div_rpm", int'(rpm_out), 0);
        check_val("rst_div_stalled", int'(stalled), 1);
        edge_tick(0, lat, val);
        check_val("post_rst_arm_no_update", lat, -1);
        idle_ticks(999);
        edge_tick(0, lat, val);
        check_val("p1000_rpm", val, 50);
        check_val("p1000_stalled", int'(stalled), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
